eq_mac_scheduler: RTL

Time-multiplexed three-band equalizer engine: one shared DW×DW multiplier sequenced by an FSM computes the low, middle and high IIR bands for the left and right channels once per audio frame. Sits between the I2S receiver output and the I2S transmitter input, started by the frame pulse. Replaces six parallel filter instances and their many multipliers with a single datapath.

---
 rtl/eq_mac_scheduler.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/eq_mac_scheduler.sv
// rtl/eq_mac_scheduler.sv - three-band stereo IIR equalizer sharing one DWxDW multiplier
// Optional output saturation of the channel accumulator: define EQ_SAT_EN.
module eq_mac_scheduler #(
  parameter int DW = 32,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] lgain,
  input  logic [DW-1:0] mgain,
  input  logic [DW-1:0] hgain,
  output logic [DW-1:0] out_l,
  output logic [DW-1:0] out_r,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  localparam logic [DW-1:0] LOW_G   = DW'(7);
  localparam logic [DW-1:0] LOW_N0  = DW'(256);
  localparam logic [DW-1:0] LOW_N1  = DW'(256);
  localparam logic [DW-1:0] LOW_N2  = DW'(0);
  localparam logic [DW-1:0] LOW_D1  = DW'(-243);
  localparam logic [DW-1:0] LOW_D2  = DW'(0);
  localparam logic [DW-1:0] MID_G   = DW'(31);
  localparam logic [DW-1:0] MID_N0  = DW'(256);
  localparam logic [DW-1:0] MID_N1  = DW'(0);
  localparam logic [DW-1:0] MID_N2  = DW'(-256);
  localparam logic [DW-1:0] MID_D1  = DW'(-446);
  localparam logic [DW-1:0] MID_D2  = DW'(194);
  localparam logic [DW-1:0] HIGH_G  = DW'(220);
  localparam logic [DW-1:0] HIGH_N0 = DW'(256);
  localparam logic [DW-1:0] HIGH_N1 = DW'(-256);
  localparam logic [DW-1:0] HIGH_N2 = DW'(0);
  localparam logic [DW-1:0] HIGH_D1 = DW'(-183);
  localparam logic [DW-1:0] HIGH_D2 = DW'(0);

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [1:0]    band_q, band_d;
  logic          chan_q, chan_d;
  logic [DW-1:0] inl_q, inl_d, inr_q, inr_d;
  logic [DW-1:0] lg_q, lg_d, mg_q, mg_d, hg_q, hg_d;
  logic [DW-1:0] o_q, o_d, pd1_q, pd1_d, pd2_q, pd2_d;
  logic [DW-1:0] pn1_q, pn1_d, pn2_q, pn2_d, y_q, y_d;
  logic [DW+1:0] acc_q, acc_d;
  logic [DW-1:0] z0_q [6];
  logic [DW-1:0] z0_d [6];
  logic [DW-1:0] z1_q [6];
  logic [DW-1:0] z1_d [6];
  logic [DW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DW-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic          done_q, done_d;

  logic [DW-1:0]          x, c_g, c_n0, c_n1, c_n2, c_d1, c_d2, gain;
  logic [DW-1:0]          mul_a, mul_b, term, res;
  logic signed [2*DW-1:0] prod;
  logic [2:0]             idx;

`ifdef EQ_SAT_EN
  function automatic logic [DW-1:0] clamp(input logic [DW+1:0] a);
    if (a[DW+1:DW-1] == 3'b000 || a[DW+1:DW-1] == 3'b111) return a[DW-1:0];
    else if (a[DW+1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
  endfunction
`endif

  // Operand routing for the single shared multiplier
  always_comb begin
    x    = chan_q ? inr_q : inl_q;
    idx  = (chan_q ? 3'd3 : 3'd0) + {1'b0, band_q};
    c_g  = LOW_G;  c_n0 = LOW_N0; c_n1 = LOW_N1; c_n2 = LOW_N2;
    c_d1 = LOW_D1; c_d2 = LOW_D2; gain = lg_q;
    case (band_q)
      2'd1: begin
        c_g  = MID_G;  c_n0 = MID_N0; c_n1 = MID_N1; c_n2 = MID_N2;
        c_d1 = MID_D1; c_d2 = MID_D2; gain = mg_q;
      end
      2'd2: begin
        c_g  = HIGH_G;  c_n0 = HIGH_N0; c_n1 = HIGH_N1; c_n2 = HIGH_N2;
        c_d1 = HIGH_D1; c_d2 = HIGH_D2; gain = hg_q;
      end
      default: ;
    endcase
    mul_a = x;
    mul_b = c_n0;
    case (step_q)
      3'd1: begin mul_a = o_q; mul_b = c_d1; end
      3'd2: begin mul_a = o_q; mul_b = c_d2; end
      3'd3: begin mul_a = x;   mul_b = c_n1; end
      3'd4: begin mul_a = x;   mul_b = c_n2; end
      3'd5: begin mul_a = o_q; mul_b = c_g;  end
      3'd6: begin mul_a = y_q; mul_b = gain; end
      default: ;
    endcase
    prod = $signed(mul_a) * $signed(mul_b);
    term = (step_q == 3'd6) ? DW'(prod >>> 12) : DW'(prod >>> FW);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    band_d   = band_q;
    chan_d   = chan_q;
    inl_d    = inl_q;
    inr_d    = inr_q;
    lg_d     = lg_q;
    mg_d     = mg_q;
    hg_d     = hg_q;
    o_d      = o_q;
    pd1_d    = pd1_q;
    pd2_d    = pd2_q;
    pn1_d    = pn1_q;
    pn2_d    = pn2_q;
    y_d      = y_q;
    acc_d    = acc_q;
    z0_d     = z0_q;
    z1_d     = z1_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    done_d   = 1'b0;
    res      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          inl_d   = in_l;
          inr_d   = in_r;
          lg_d    = lgain;
          mg_d    = mgain;
          hg_d    = hgain;
          step_d  = 3'd0;
          band_d  = 2'd0;
          chan_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        case (step_q)
          3'd0: o_d   = term + z0_q[idx];
          3'd1: pd1_d = term;
          3'd2: pd2_d = term;
          3'd3: pn1_d = term;
          3'd4: pn2_d = term;
          3'd5: y_d   = term;
          default: begin
            // Accumulator restarts at each channel's low band
            acc_d     = ((band_q == 2'd0) ? '0 : acc_q) + {{2{term[DW-1]}}, term};
            z1_d[idx] = pn2_q - pd2_q;
            z0_d[idx] = pn1_q - pd1_q + z1_q[idx];
`ifdef EQ_SAT_EN
            res = clamp(acc_d);
`else
            res = acc_d[DW-1:0];
`endif
            if (band_q == 2'd2) begin
              if (chan_q) hold_r_d = res;
              else        hold_l_d = res;
            end
          end
        endcase
        if (step_q == 3'd6) begin
          step_d = 3'd0;
          if (band_q == 2'd2) begin
            band_d = 2'd0;
            if (chan_q) state_d = S_OUT;
            else        chan_d  = 1'b1;
          end else begin
            band_d = band_q + 2'd1;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_OUT: begin
        out_l_d = hold_l_q;
        out_r_d = hold_r_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      band_q   <= '0;
      chan_q   <= 1'b0;
      inl_q    <= '0;
      inr_q    <= '0;
      lg_q     <= '0;
      mg_q     <= '0;
      hg_q     <= '0;
      o_q      <= '0;
      pd1_q    <= '0;
      pd2_q    <= '0;
      pn1_q    <= '0;
      pn2_q    <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      for (int i = 0; i < 6; i++) begin
        z0_q[i] <= '0;
        z1_q[i] <= '0;
      end
      hold_l_q <= '0;
      hold_r_q <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      band_q   <= band_d;
      chan_q   <= chan_d;
      inl_q    <= inl_d;
      inr_q    <= inr_d;
      lg_q     <= lg_d;
      mg_q     <= mg_d;
      hg_q     <= hg_d;
      o_q      <= o_d;
      pd1_q    <= pd1_d;
      pd2_q    <= pd2_d;
      pn1_q    <= pn1_d;
      pn2_q    <= pn2_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      z0_q     <= z0_d;
      z1_q     <= z1_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      done_q   <= done_d;
    end
  end

  // busy covers the done cycle, which the FSM spends already back in IDLE
  assign busy  = (state_q != S_IDLE) || done_q;
  assign done  = done_q;
  assign out_l = out_l_q;
  assign out_r = out_r_q;

endmodule
